matrix_port_arbiter: RTL and testbench



---
 rtl/matrix_port_arbiter_if.sv | 41 ++++
 rtl/matrix_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_matrix_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_port_arbiter_if.sv
// Bus bundle for matrix_port_arbiter: requesters A/B, clear control and the frame-RAM port.
// Handshake: a requester raises x_REQ with x_WE/x_ADDR/x_DATA stable and holds them until
// x_GNT is high in the same cycle; that cycle is the transfer. Reads answer later with a
// one-cycle x_RVALID carrying x_RDATA. Dropping x_REQ before a grant is allowed.
interface matrix_port_arbiter_if;
   logic        A_REQ;
   logic        A_WE;
   logic [2:0]  A_ADDR;
   logic [15:0] A_DATA;
   logic        A_GNT;
   logic        A_RVALID;
   logic [15:0] A_RDATA;
   logic        B_REQ;
   logic        B_WE;
   logic [2:0]  B_ADDR;
   logic [15:0] B_DATA;
   logic        B_GNT;
   logic        B_RVALID;
   logic [15:0] B_RDATA;
   logic        CLR;
   logic [15:0] CLR_DATA;
   logic        CLR_BUSY;
   logic [2:0]  M_ADDR;
   logic [15:0] M_DATA;
   logic        M_WREN;
   logic [15:0] M_Q;

   modport slave (
      input  A_REQ, A_WE, A_ADDR, A_DATA, B_REQ, B_WE, B_ADDR, B_DATA,
      input  CLR, CLR_DATA, M_Q,
      output A_GNT, A_RVALID, A_RDATA, B_GNT, B_RVALID, B_RDATA,
      output CLR_BUSY, M_ADDR, M_DATA, M_WREN
   );

   modport master (
      output A_REQ, A_WE, A_ADDR, A_DATA, B_REQ, B_WE, B_ADDR, B_DATA,
      output CLR, CLR_DATA, M_Q,
      input  A_GNT, A_RVALID, A_RDATA, B_GNT, B_RVALID, B_RDATA,
      input  CLR_BUSY, M_ADDR, M_DATA, M_WREN
   );
endinterface

// File: rtl/matrix_port_arbiter.sv
// Round-robin arbiter for matrix frame-RAM port A with a registered one-access-per-cycle datapath.
// Build option MATRIX_ARB_CLEAR_EN compiles in the CLEAR sequencer that fills all 8 lines.
module matrix_port_arbiter (
   input  logic                 CLK,
   input  logic                 RST,
   matrix_port_arbiter_if.slave bus,
   output logic                 o_dbg_state
);
   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_last;
   logic        w_arb_en;
   logic        w_gnt_a, w_gnt_b, w_gnt;
   logic        w_sel_we;
   logic [2:0]  w_sel_addr;
   logic [15:0] w_sel_data;
   logic [2:0]  r_m_addr;
   logic [15:0] r_m_data;
   logic        r_m_wren;
   logic        r_p1_vld, r_p1_b, r_p2_vld, r_p2_b;
   logic        r_a_rvalid, r_b_rvalid;
   logic [15:0] r_a_rdata, r_b_rdata;
`ifdef MATRIX_ARB_CLEAR_EN
   logic        w_clr_go;
   logic [2:0]  r_cnt;
   logic [15:0] r_fill;
`else
   logic        w_unused_clr;
   assign w_unused_clr = ^{bus.CLR, bus.CLR_DATA};
`endif

   always_ff @(posedge CLK) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_arb_en    = 1'b0;
`ifdef MATRIX_ARB_CLEAR_EN
      w_clr_go    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.CLR) begin
               w_clr_go    = 1'b1;
               w_state_nxt = ST_CLEAR;
            end else begin
               w_arb_en = 1'b1;
            end
         end
         ST_CLEAR: begin
            // The last fill write is already on M_*, so this cycle may grant again.
            if (r_cnt == 3'd7) begin
               w_arb_en    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (RST) w_clr_go = 1'b0;
`else
      w_arb_en    = 1'b1;
      w_state_nxt = ST_IDLE;
`endif
      if (RST) w_arb_en = 1'b0;
   end

   // r_last = 1 means B held the previous grant, so A wins the next contention.
   assign w_gnt_a    = w_arb_en & bus.A_REQ & (~bus.B_REQ | r_last);
   assign w_gnt_b    = w_arb_en & bus.B_REQ & (~bus.A_REQ | ~r_last);
   assign w_gnt      = w_gnt_a | w_gnt_b;
   assign w_sel_we   = w_gnt_b ? bus.B_WE   : bus.A_WE;
   assign w_sel_addr = w_gnt_b ? bus.B_ADDR : bus.A_ADDR;
   assign w_sel_data = w_gnt_b ? bus.B_DATA : bus.A_DATA;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_last     <= 1'b1;
         r_m_addr   <= '0;
         r_m_data   <= '0;
         r_m_wren   <= 1'b0;
         r_p1_vld   <= 1'b0;
         r_p1_b     <= 1'b0;
         r_p2_vld   <= 1'b0;
         r_p2_b     <= 1'b0;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
`ifdef MATRIX_ARB_CLEAR_EN
         r_cnt      <= '0;
         r_fill     <= '0;
`endif
      end else begin
         r_m_wren <= 1'b0;
         if (w_gnt) begin
            r_m_addr <= w_sel_addr;
            r_m_data <= w_sel_data;
            r_m_wren <= w_sel_we;
            r_last   <= w_gnt_b;
`ifdef MATRIX_ARB_CLEAR_EN
         end else if (w_clr_go) begin
            r_fill   <= bus.CLR_DATA;
            r_cnt    <= 3'd0;
            r_m_addr <= 3'd0;
            r_m_data <= bus.CLR_DATA;
            r_m_wren <= 1'b1;
         end else if ((r_state == ST_CLEAR) && (r_cnt != 3'd7)) begin
            r_cnt    <= r_cnt + 3'd1;
            r_m_addr <= r_cnt + 3'd1;
            r_m_data <= r_fill;
            r_m_wren <= 1'b1;
`endif
         end
         // Read tag: stage 1 = address on M_*, stage 2 = M_Q valid, then capture.
         r_p1_vld   <= w_gnt & ~w_sel_we;
         r_p1_b     <= w_gnt_b;
         r_p2_vld   <= r_p1_vld;
         r_p2_b     <= r_p1_b;
         r_a_rvalid <= r_p2_vld & ~r_p2_b;
         r_b_rvalid <= r_p2_vld & r_p2_b;
         if (r_p2_vld && !r_p2_b) r_a_rdata <= bus.M_Q;
         if (r_p2_vld && r_p2_b)  r_b_rdata <= bus.M_Q;
      end
   end

   assign bus.A_GNT    = w_gnt_a;
   assign bus.B_GNT    = w_gnt_b;
   assign bus.A_RVALID = r_a_rvalid;
   assign bus.B_RVALID = r_b_rvalid;
   assign bus.A_RDATA  = r_a_rdata;
   assign bus.B_RDATA  = r_b_rdata;
   assign bus.M_ADDR   = r_m_addr;
   assign bus.M_DATA   = r_m_data;
   assign bus.M_WREN   = r_m_wren;
`ifdef MATRIX_ARB_CLEAR_EN
   assign bus.CLR_BUSY = (r_state == ST_CLEAR);
`else
   assign bus.CLR_BUSY = 1'b0;
`endif
   assign o_dbg_state  = (r_state == ST_CLEAR);
endmodule

// File: tb/tb_matrix_port_arbiter.sv
// Directed bench for matrix_port_arbiter with a behavioural frame-RAM on the M_* port.
// Clear-sequencer cases follow MATRIX_ARB_CLEAR_EN; the disabled build checks CLR is ignored.
module tb_matrix_port_arbiter;
   logic clk;
   logic rst;
   logic ram_init;
   logic dbg_state;
   int   n_total;
   int   n_bad;
   logic [15:0] ram [0:7];
   logic [7:0]  exp_ag, exp_bg, exp_arv, exp_brv;

   matrix_port_arbiter_if bus ();

   matrix_port_arbiter dut (
      .CLK         (clk),
      .RST         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame RAM: written at the end of the WREN cycle, Q one cycle after the address.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 8; i++) ram[i] <= 16'(16'h1000 + i);
      end else if (bus.M_WREN) begin
         ram[bus.M_ADDR] <= bus.M_DATA;
      end
      bus.M_Q <= ram[bus.M_ADDR];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_a(input logic req, input logic we, input logic [2:0] addr, input logic [15:0] data);
      bus.A_REQ = req; bus.A_WE = we; bus.A_ADDR = addr; bus.A_DATA = data;
   endtask

   task automatic set_b(input logic req, input logic we, input logic [2:0] addr, input logic [15:0] data);
      bus.B_REQ = req; bus.B_WE = we; bus.B_ADDR = addr; bus.B_DATA = data;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst = 1'b1;
      ram_init = 1'b1;
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      bus.CLR = 1'b0;
      bus.CLR_DATA = '0;

      // Reset values, grants held off while RST is high
      step();
      ram_init = 1'b0;
      set_a(1, 1, 3'd2, 16'h1234);
      set_b(1, 1, 3'd2, 16'h4321);
      settle();
      chk("rst_a_gnt", bus.A_GNT, 0);
      chk("rst_b_gnt", bus.B_GNT, 0);
      chk("rst_m_wren", bus.M_WREN, 0);
      chk("rst_m_addr", bus.M_ADDR, 0);
      chk("rst_m_data", bus.M_DATA, 0);
      chk("rst_rvalid", {bus.A_RVALID, bus.B_RVALID}, 0);
      chk("rst_rdata", {bus.A_RDATA, bus.B_RDATA}, 0);
      chk("rst_busy", bus.CLR_BUSY, 0);
      chk("rst_state", dbg_state, 0);
      step();

      // A writes line 3 then reads it back
      rst = 1'b0;
      set_b(0, 0, 0, 0);
      set_a(1, 1, 3'd3, 16'hA55A);
      settle();
      chk("t1_wr_gnt", bus.A_GNT, 1);
      chk("t1_wr_bgnt", bus.B_GNT, 0);
      step();
      chk("t1_m_wren", bus.M_WREN, 1);
      chk("t1_m_addr", bus.M_ADDR, 3);
      chk("t1_m_data", bus.M_DATA, 16'hA55A);
      set_a(1, 0, 3'd3, 16'h0);
      settle();
      chk("t1_rd_gnt", bus.A_GNT, 1);
      step();
      chk("t1_rd_wren", bus.M_WREN, 0);
      set_a(0, 0, 0, 0);
      step();
      chk("t1_rv_early", bus.A_RVALID, 0);
      step();
      chk("t1_a_rvalid", bus.A_RVALID, 1);
      chk("t1_a_rdata", bus.A_RDATA, 16'hA55A);
      chk("t1_b_rvalid", bus.B_RVALID, 0);
      step();
      chk("t1_rv_pulse", bus.A_RVALID, 0);
      chk("t1_rdata_hold", bus.A_RDATA, 16'hA55A);

      // B writes line 2, then A/B read contention alternates starting with A
      set_b(1, 1, 3'd2, 16'h2222);
      settle();
      chk("t2_bwr_gnt", bus.B_GNT, 1);
      step();
      exp_ag  = 8'b0000_0101;
      exp_bg  = 8'b0000_1010;
      exp_arv = 8'b0010_1000;
      exp_brv = 8'b0101_0000;
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            set_a(1, 0, 3'd1, 16'h0);
            set_b(1, 0, 3'd2, 16'h0);
         end else begin
            set_a(0, 0, 0, 0);
            set_b(0, 0, 0, 0);
         end
         settle();
         chk($sformatf("t2_a_gnt_%0d", k), bus.A_GNT, exp_ag[k]);
         chk($sformatf("t2_b_gnt_%0d", k), bus.B_GNT, exp_bg[k]);
         chk($sformatf("t2_a_rv_%0d", k), bus.A_RVALID, exp_arv[k]);
         chk($sformatf("t2_b_rv_%0d", k), bus.B_RVALID, exp_brv[k]);
         if (exp_arv[k]) chk($sformatf("t2_a_rd_%0d", k), bus.A_RDATA, 16'h1001);
         if (exp_brv[k]) chk($sformatf("t2_b_rd_%0d", k), bus.B_RDATA, 16'h2222);
         step();
      end

      // B write vs A read on line 7, A ordered first (B was last): old value
      set_a(1, 0, 3'd7, 16'h0);
      set_b(1, 1, 3'd7, 16'h00FF);
      settle();
      chk("t3a_a_gnt", bus.A_GNT, 1);
      chk("t3a_b_gnt", bus.B_GNT, 0);
      step();
      set_a(0, 0, 0, 0);
      settle();
      chk("t3a_b_gnt2", bus.B_GNT, 1);
      step();
      set_b(0, 0, 0, 0);
      step();
      chk("t3a_a_rvalid", bus.A_RVALID, 1);
      chk("t3a_a_rdata", bus.A_RDATA, 16'h1007);
      chk("t3a_b_rvalid", bus.B_RVALID, 0);

      // A granted alone, then contention: B first, A reads B's new data
      set_a(1, 1, 3'd6, 16'h6666);
      settle();
      chk("t3b_a_wr", bus.A_GNT, 1);
      step();
      set_a(1, 0, 3'd7, 16'h0);
      set_b(1, 1, 3'd7, 16'hF0F0);
      settle();
      chk("t3b_b_gnt", bus.B_GNT, 1);
      chk("t3b_a_gnt", bus.A_GNT, 0);
      step();
      set_b(0, 0, 0, 0);
      settle();
      chk("t3b_a_gnt2", bus.A_GNT, 1);
      step();
      set_a(0, 0, 0, 0);
      step();
      step();
      chk("t3b_a_rvalid", bus.A_RVALID, 1);
      chk("t3b_a_rdata", bus.A_RDATA, 16'hF0F0);

`ifdef MATRIX_ARB_CLEAR_EN
      // Clear with FF00 while A waits to read line 0
      set_a(1, 0, 3'd0, 16'h0);
      bus.CLR = 1'b1;
      bus.CLR_DATA = 16'hFF00;
      settle();
      chk("t4_clr_gnt", bus.A_GNT, 0);
      chk("t4_clr_busy0", bus.CLR_BUSY, 0);
      step();
      bus.CLR = 1'b0;
      bus.CLR_DATA = 16'h0BAD;
      for (int k = 1; k <= 8; k++) begin
         settle();
         chk($sformatf("t4_busy_%0d", k), bus.CLR_BUSY, 1);
         chk($sformatf("t4_state_%0d", k), dbg_state, 1);
         chk($sformatf("t4_wren_%0d", k), bus.M_WREN, 1);
         chk($sformatf("t4_addr_%0d", k), bus.M_ADDR, k - 1);
         chk($sformatf("t4_data_%0d", k), bus.M_DATA, 16'hFF00);
         chk($sformatf("t4_a_gnt_%0d", k), bus.A_GNT, (k == 8));
         if (k < 8) step();
      end
      for (int i = 0; i < 12; i++) begin
         if (i < 8) set_a(1, 0, 3'(i), 16'h0);
         else       set_a(0, 0, 0, 0);
         settle();
         if (i < 8) chk($sformatf("t4_rd_gnt_%0d", i), bus.A_GNT, 1);
         if (i == 1) chk("t4_busy_end", bus.CLR_BUSY, 0);
         chk($sformatf("t4_rv_%0d", i), bus.A_RVALID, (i >= 3 && i < 11));
         if (i >= 3 && i < 11) chk($sformatf("t4_rd_%0d", i), bus.A_RDATA, 16'hFF00);
         step();
      end

      // Reset during the 4th clear write
      bus.CLR = 1'b1;
      bus.CLR_DATA = 16'h1234;
      step();
      bus.CLR = 1'b0;
      step();
      step();
      step();
      settle();
      chk("t5_m_addr3", bus.M_ADDR, 3);
      chk("t5_m_wren3", bus.M_WREN, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      settle();
      chk("t5_post_wren", bus.M_WREN, 0);
      chk("t5_post_busy", bus.CLR_BUSY, 0);
      chk("t5_post_state", dbg_state, 0);
      step();
`else
      // CLR pulse ignored: no busy, no writes
      bus.CLR = 1'b1;
      bus.CLR_DATA = 16'hFF00;
      settle();
      chk("t4_busy0", bus.CLR_BUSY, 0);
      step();
      bus.CLR = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         settle();
         chk($sformatf("t4_busy_%0d", k), bus.CLR_BUSY, 0);
         chk($sformatf("t4_wren_%0d", k), bus.M_WREN, 0);
         chk($sformatf("t4_state_%0d", k), dbg_state, 0);
         step();
      end
      // CLR high does not block a grant
      bus.CLR = 1'b1;
      set_a(1, 0, 3'd7, 16'h0);
      settle();
      chk("t4_gnt_clr", bus.A_GNT, 1);
      step();
      bus.CLR = 1'b0;
      set_a(0, 0, 0, 0);
      step();
      step();
      chk("t4_rvalid", bus.A_RVALID, 1);
      chk("t4_rdata", bus.A_RDATA, 16'hF0F0);
      step();
`endif

      // Reset with an A read in flight; last pointer returns to favour A
      set_a(1, 0, 3'd4, 16'h0);
      settle();
      chk("t6_a_gnt", bus.A_GNT, 1);
      step();
      rst = 1'b1;
      settle();
      chk("t6_rst_gnt", bus.A_GNT, 0);
      step();
      rst = 1'b0;
      set_a(0, 0, 0, 0);
      settle();
      chk("t6_rv_a", bus.A_RVALID, 0);
      chk("t6_rdata_rst", bus.A_RDATA, 0);
      step();
      chk("t6_rv_b", bus.A_RVALID, 0);
      set_a(1, 1, 3'd0, 16'h0001);
      set_b(1, 1, 3'd1, 16'h0002);
      settle();
      chk("t6_cont_a", bus.A_GNT, 1);
      chk("t6_cont_b", bus.B_GNT, 0);
      step();
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
      chk("t6_m_addr", bus.M_ADDR, 0);
      chk("t6_m_data", bus.M_DATA, 16'h0001);
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
